// File: rtl/conv_unit_pkg.sv
// conv_unit_pkg: type, trap and op codes shared by the conversion unit and the core.
package conv_unit_pkg;

    typedef enum logic [1:0] {T_I32, T_I64, T_F32, T_F64} conv_type_t;

    localparam logic [2:0] TRAP_NONE          = 3'd0;
    localparam logic [2:0] TRAP_INT_OVERFLOW  = 3'd4;
    localparam logic [2:0] TRAP_INVALID_CONV  = 3'd5;
    localparam logic [2:0] TRAP_TYPE_MISMATCH = 3'd6;
    localparam logic [2:0] TRAP_UNSUPPORTED   = 3'd7;

    localparam logic [4:0] CONV_OP_WRAP         = 5'd0;
    localparam logic [4:0] CONV_OP_EXTEND_S     = 5'd1;
    localparam logic [4:0] CONV_OP_EXTEND_U     = 5'd2;
    localparam logic [4:0] CONV_OP_I32_REINT    = 5'd3;
    localparam logic [4:0] CONV_OP_I64_REINT    = 5'd4;
    localparam logic [4:0] CONV_OP_F32_REINT    = 5'd5;
    localparam logic [4:0] CONV_OP_F64_REINT    = 5'd6;
    localparam logic [4:0] CONV_OP_I32_EXT8     = 5'd7;
    localparam logic [4:0] CONV_OP_I32_EXT16    = 5'd8;
    localparam logic [4:0] CONV_OP_I64_EXT8     = 5'd9;
    localparam logic [4:0] CONV_OP_I64_EXT16    = 5'd10;
    localparam logic [4:0] CONV_OP_I64_EXT32    = 5'd11;
    localparam logic [4:0] CONV_OP_TRUNC        = 5'd12;
    localparam logic [4:0] CONV_OP_TRUNC_SAT    = 5'd20;
    localparam logic [4:0] CONV_OP_RSVD         = 5'd28;

    typedef struct packed {
        logic [63:0] result;
        conv_type_t  rtype;
        logic [2:0]  trap;
    } conv_res_t;

    // Trunc ops sit on a multiple of 4, so op[1] selects f64 source and op[2] clear means i64 target.
    function automatic conv_type_t op_in_type(input logic [4:0] op);
        if (op >= CONV_OP_TRUNC) return op[1] ? T_F64 : T_F32;
        case (op)
            CONV_OP_WRAP, CONV_OP_F64_REINT, CONV_OP_I64_EXT8,
            CONV_OP_I64_EXT16, CONV_OP_I64_EXT32:              return T_I64;
            CONV_OP_I32_REINT:                                 return T_F32;
            CONV_OP_I64_REINT:                                 return T_F64;
            default:                                           return T_I32;
        endcase
    endfunction

    function automatic conv_type_t op_out_type(input logic [4:0] op);
        if (op >= CONV_OP_RSVD) return T_I64;
        if (op >= CONV_OP_TRUNC) return op[2] ? T_I32 : T_I64;
        case (op)
            CONV_OP_WRAP, CONV_OP_I32_REINT,
            CONV_OP_I32_EXT8, CONV_OP_I32_EXT16: return T_I32;
            CONV_OP_F32_REINT:                   return T_F32;
            CONV_OP_F64_REINT:                   return T_F64;
            default:                             return T_I64;
        endcase
    endfunction

endpackage

// File: rtl/conv_trunc.sv
// conv_trunc: combinational float-to-int truncation with range check and saturation.
module conv_trunc (
    input  logic [63:0] bits,
    input  logic        is_f64,
    input  logic        sgn,
    input  logic        to_i64,
    input  logic        sat,
    output logic [63:0] value,
    output logic        invalid,
    output logic        overflow
);
    logic signed [12:0] e;
    logic        neg, nan, big, ovf;
    logic [52:0] sig;
    logic [63:0] mag, mask;
    logic [64:0] lim, tr, clamp;

    always_comb begin
        neg  = is_f64 ? bits[63] : bits[31];
        e    = is_f64 ? $signed({2'b0, bits[62:52]}) - 13'sd1023 : $signed({5'b0, bits[30:23]}) - 13'sd127;
        nan  = is_f64 ? (&bits[62:52] && |bits[51:0]) : (&bits[30:23] && |bits[22:0]);
        sig  = is_f64 ? {1'b1, bits[51:0]} : {1'b1, bits[22:0], 29'b0};
        big  = e > 13'sd63;
        mag  = e < 13'sd0 ? 64'd0 : e >= 13'sd52 ? {11'b0, sig} << 6'(e - 13'sd52) : {11'b0, sig} >> 6'(13'sd52 - e);
        mask = to_i64 ? '1 : 64'h0000_0000_FFFF_FFFF;
        // Largest magnitude allowed on this side of zero; negative unsigned only admits zero.
        lim  = !sgn ? (neg ? 65'd0 : {1'b0, mask}) : neg ? ({1'b0, mask} >> 1) + 65'd1 : {1'b0, mask} >> 1;
        ovf  = big || {1'b0, mag} > lim;
        tr   = neg ? -{1'b0, mag} : {1'b0, mag};
        clamp = neg ? -lim : lim;
        value    = nan ? 64'd0 : ((ovf ? clamp[63:0] : tr[63:0]) & mask);
        invalid  = nan && !sat;
        overflow = !nan && ovf && !sat;
    end
endmodule

// File: rtl/conv_unit.sv
// conv_unit: pipelined WebAssembly numeric conversion unit with elastic result stages.
module conv_unit
    import conv_unit_pkg::*;
#(
    parameter int STAGES       = 2,
    parameter int ENABLE_TRUNC = 1,
    parameter int ENABLE_SAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  op,
    input  logic [63:0] operand,
    input  logic [1:0]  operand_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [1:0]  result_type,
    output logic [2:0]  trap,
    output logic        busy
);
    localparam int L = STAGES - 1;

    logic        is_trunc, is_sat, unsupported, mismatch, t_inv, t_ovf;
    logic [63:0] tv, val;
    logic [2:0]  tcode;
    conv_res_t   comp;

    conv_trunc u_trunc (
        .bits(operand), .is_f64(op[1]), .sgn(!op[0]), .to_i64(!op[2]), .sat(is_sat),
        .value(tv), .invalid(t_inv), .overflow(t_ovf)
    );

    always_comb begin
        is_trunc    = op >= CONV_OP_TRUNC && op < CONV_OP_RSVD;
        is_sat      = op >= CONV_OP_TRUNC_SAT && op < CONV_OP_RSVD;
        unsupported = op >= CONV_OP_RSVD || (is_trunc && ENABLE_TRUNC == 0) || (is_sat && ENABLE_SAT == 0);
        mismatch    = conv_type_t'(operand_type) != op_in_type(op);
        case (op)
            CONV_OP_WRAP, CONV_OP_EXTEND_U,
            CONV_OP_I32_REINT, CONV_OP_F32_REINT: val = {32'b0, operand[31:0]};
            CONV_OP_EXTEND_S, CONV_OP_I64_EXT32:  val = {{32{operand[31]}}, operand[31:0]};
            CONV_OP_I64_REINT, CONV_OP_F64_REINT: val = operand;
            CONV_OP_I32_EXT8:  val = {32'b0, {24{operand[7]}}, operand[7:0]};
            CONV_OP_I32_EXT16: val = {32'b0, {16{operand[15]}}, operand[15:0]};
            CONV_OP_I64_EXT8:  val = {{56{operand[7]}}, operand[7:0]};
            CONV_OP_I64_EXT16: val = {{48{operand[15]}}, operand[15:0]};
            default:           val = tv;
        endcase
        tcode = unsupported ? TRAP_UNSUPPORTED : mismatch ? TRAP_TYPE_MISMATCH :
                (is_trunc && t_inv) ? TRAP_INVALID_CONV : (is_trunc && t_ovf) ? TRAP_INT_OVERFLOW : TRAP_NONE;
        comp.result = tcode != TRAP_NONE ? 64'd0 : val;
        comp.rtype  = op_out_type(op);
        comp.trap   = tcode;
    end

    logic [STAGES-1:0] v, rdy;
    logic [STAGES:0]   vsrc;
    conv_res_t         stg  [STAGES];
    conv_res_t         dsrc [STAGES+1];

    assign vsrc    = {v, in_valid};
    assign dsrc[0] = comp;

    // A stage can load if anything at or beyond it is empty, or the output drains this cycle.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        assign rdy[g]    = out_ready || !(&v[L:g]);
        assign dsrc[g+1] = stg[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) stg[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v[i] <= vsrc[i];
                    if (vsrc[i]) stg[i] <= dsrc[i];
                end
            end
        end
    end

    assign in_ready    = rdy[0];
    assign out_valid   = v[L];
    assign result      = stg[L].result;
    assign result_type = stg[L].rtype;
    assign trap        = stg[L].trap;
    assign busy        = |v;
endmodule
